axi_write_arbiter_rr: RTL

// - Parametrised AXI write-path arbiter for NUM_M masters and NUM_S slaves, sitting in the AXI bridge.
// - Round-robin arbitration on AW, with address decode to a slave; unmapped addresses go to the default slave.
// - Holds the AW/W/B routing for one outstanding write burst and emits one-hot grant/select vectors.
// - The bridge muxes use these vectors. One transaction in flight at a time.

---
 rtl/axi_arb_pkg.sv | 26 ++
 rtl/axi_write_arbiter_rr_if.sv | 40 ++++
 rtl/rr_arbiter.sv | 39 +++
 rtl/axi_write_arbiter_rr.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// Shared types and helpers for the AXI write-path round-robin arbiter.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_AW   = 2'd1,
    ARB_W    = 2'd2,
    ARB_B    = 2'd3
  } arb_state_e;

  // Widest one-hot vector the helper can build; bounds NUM_M and NUM_S.
  localparam int unsigned ONEHOT_MAX = 32;

  // Index width for n choices; a single choice still gets one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One-hot of idx, or all-zero when en is low.
  function automatic logic [ONEHOT_MAX-1:0] onehot(input int unsigned idx, input logic en);
    logic [ONEHOT_MAX-1:0] one;
    one = {{(ONEHOT_MAX-1){1'b0}}, en};
    return one << idx;
  endfunction

endpackage

// File: rtl/axi_write_arbiter_rr_if.sv
// Bus bundle between the write arbiter and the bridge: per-master/per-slave
// handshake inputs and the one-hot grant/select vectors the bridge muxes use.
interface axi_write_arbiter_rr_if #(
  parameter int NUM_M  = 2,
  parameter int NUM_S  = 3,
  parameter int ADDR_W = 32
);

  logic [NUM_M*ADDR_W-1:0] AWADDR_M;
  logic [NUM_M-1:0]        AWVALID_M;
  logic [NUM_S-1:0]        AWREADY_S;
  logic [NUM_M-1:0]        WVALID_M;
  logic [NUM_M-1:0]        WLAST_M;
  logic [NUM_S-1:0]        WREADY_S;
  logic [NUM_S-1:0]        BVALID_S;
  logic [NUM_M-1:0]        BREADY_M;

  logic [NUM_M-1:0]        aw_gnt_m;
  logic [NUM_S-1:0]        aw_sel_s;
  logic [NUM_M-1:0]        w_gnt_m;
  logic [NUM_S-1:0]        w_sel_s;
  logic [NUM_M-1:0]        b_gnt_m;
  logic [NUM_S-1:0]        b_sel_s;
  logic                    busy;

  // Arbiter side: observes the handshakes, drives the routing vectors.
  modport slave (
    input  AWADDR_M, AWVALID_M, AWREADY_S, WVALID_M, WLAST_M, WREADY_S,
           BVALID_S, BREADY_M,
    output aw_gnt_m, aw_sel_s, w_gnt_m, w_sel_s, b_gnt_m, b_sel_s, busy
  );

  // Bridge side: supplies the handshakes, consumes the routing vectors.
  modport master (
    output AWADDR_M, AWVALID_M, AWREADY_S, WVALID_M, WLAST_M, WREADY_S,
           BVALID_S, BREADY_M,
    input  aw_gnt_m, aw_sel_s, w_gnt_m, w_sel_s, b_gnt_m, b_sel_s, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// searching cyclically. ptr is assumed to be < N.
module rr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [idx_w(N)-1:0]  ptr,
  output logic [idx_w(N)-1:0]  gnt_idx,
  output logic                 valid
);

  localparam int unsigned IW = idx_w(N);
  localparam int unsigned KW = IW + 1;
  localparam int unsigned PW = 1 << IW;

  // Padding to a power of two keeps every index exactly IW bits wide.
  logic [PW-1:0] req_pad;
  logic [KW-1:0] k;

  assign req_pad = PW'(req);

  // Walk N positions starting at ptr; the first hit wins.
  always_comb begin
    valid   = 1'b0;
    gnt_idx = '0;
    k       = '0;
    for (int i = 0; i < int'(N); i++) begin
      k = {1'b0, ptr} + KW'(i);
      if (k >= KW'(N)) k = k - KW'(N);
      if (!valid && req_pad[k[IW-1:0]]) begin
        valid   = 1'b1;
        gnt_idx = k[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/axi_write_arbiter_rr.sv
// AXI write-path arbiter: round-robin over masters on AW, address decode to a
// slave (out-of-range decode goes to DEF_S), then holds the AW/W/B routing
// for a single outstanding burst. All routing vectors are decoded from
// registered state only, so they have no combinational path from the inputs.
module axi_write_arbiter_rr
  import axi_arb_pkg::*;
#(
  parameter int NUM_M   = 2,
  parameter int NUM_S   = 3,
  parameter int ADDR_W  = 32,
  parameter int DEC_MSB = 31,
  parameter int DEC_LSB = 16,
  parameter int DEF_S   = NUM_S - 1
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  axi_write_arbiter_rr_if.slave   bus
);

  localparam int unsigned MW = idx_w(NUM_M);
  localparam int unsigned SW = idx_w(NUM_S);
  localparam int          FW = DEC_MSB - DEC_LSB + 1;

  arb_state_e              state, state_nxt;
  logic [MW-1:0]           g_idx, g_idx_nxt;
  logic [SW-1:0]           s_idx, s_idx_nxt;
  logic [MW-1:0]           rr_ptr, rr_ptr_nxt;

  logic [MW-1:0]           arb_idx;
  logic                    arb_valid;
  logic [ADDR_W-1:0]       win_addr;
  logic [FW-1:0]           dec_field;
  logic [SW-1:0]           dec_s;

  logic [ONEHOT_MAX-1:0]   g_oh_all, s_oh_all;
  logic [NUM_M-1:0]        g_oh;
  logic [NUM_S-1:0]        s_oh;
  logic                    aw_hs, w_hs_last, b_hs;
  logic                    unused;

  rr_arbiter #(.N(NUM_M)) u_rr (
    .req     (bus.AWVALID_M),
    .ptr     (rr_ptr),
    .gnt_idx (arb_idx),
    .valid   (arb_valid)
  );

  // Address of the master the round-robin picker currently favours.
  always_comb begin
    win_addr = '0;
    for (int m = 0; m < NUM_M; m++) begin
      if (arb_idx == MW'(m)) win_addr = bus.AWADDR_M[m*ADDR_W +: ADDR_W];
    end
  end

  assign dec_field = win_addr[DEC_MSB:DEC_LSB];

  // Slave decode compares the whole field, so large values never alias onto
  // a real slave through truncation.
  always_comb begin
    if (64'(dec_field) < 64'(NUM_S)) dec_s = SW'(dec_field);
    else                             dec_s = SW'(DEF_S);
  end

  // Latched master/slave as one-hot masks; used for both handshakes and outputs.
  assign g_oh_all = onehot(int'(g_idx), 1'b1);
  assign s_oh_all = onehot(int'(s_idx), 1'b1);
  assign g_oh     = g_oh_all[NUM_M-1:0];
  assign s_oh     = s_oh_all[NUM_S-1:0];

  // Address bits outside the decode field and upper mask bits are don't-care.
  assign unused = ^{win_addr, g_oh_all, s_oh_all};

  assign aw_hs     = (|(bus.AWVALID_M & g_oh)) && (|(bus.AWREADY_S & s_oh));
  assign w_hs_last = (|(bus.WVALID_M & bus.WLAST_M & g_oh)) && (|(bus.WREADY_S & s_oh));
  assign b_hs      = (|(bus.BVALID_S & s_oh)) && (|(bus.BREADY_M & g_oh));

  // State, latched routing and round-robin pointer; reset aborts any burst.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state  <= ARB_IDLE;
      g_idx  <= '0;
      s_idx  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      g_idx  <= g_idx_nxt;
      s_idx  <= s_idx_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  // Next-state logic: arbitrate only in IDLE, then follow AW -> W -> B.
  always_comb begin
    state_nxt  = state;
    g_idx_nxt  = g_idx;
    s_idx_nxt  = s_idx;
    rr_ptr_nxt = rr_ptr;
    case (state)
      ARB_IDLE: begin
        if (arb_valid) begin
          g_idx_nxt = arb_idx;
          s_idx_nxt = dec_s;
          state_nxt = ARB_AW;
        end
      end
      ARB_AW: begin
        // Grant is held even if AWVALID drops; no re-arbitration mid-burst.
        if (aw_hs) begin
          state_nxt  = ARB_W;
          rr_ptr_nxt = (g_idx == MW'(NUM_M - 1)) ? '0 : g_idx + MW'(1);
        end
      end
      ARB_W: begin
        if (w_hs_last) state_nxt = ARB_B;
      end
      ARB_B: begin
        if (b_hs) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Routing vectors: exactly one phase active at a time, all-zero in IDLE.
  always_comb begin
    bus.aw_gnt_m = '0;
    bus.aw_sel_s = '0;
    bus.w_gnt_m  = '0;
    bus.w_sel_s  = '0;
    bus.b_gnt_m  = '0;
    bus.b_sel_s  = '0;
    bus.busy     = 1'b0;
    case (state)
      ARB_AW: begin
        bus.aw_gnt_m = g_oh;
        bus.aw_sel_s = s_oh;
        bus.busy     = 1'b1;
      end
      ARB_W: begin
        bus.w_gnt_m = g_oh;
        bus.w_sel_s = s_oh;
        bus.busy    = 1'b1;
      end
      ARB_B: begin
        bus.b_gnt_m = g_oh;
        bus.b_sel_s = s_oh;
        bus.busy    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
